// File: rtl/game_ctrl_if.sv
// Character position bundle: 12-bit unsigned screen coordinates.
interface pos_if;
  logic [11:0] xpos;
  logic [11:0] ypos;

  modport in  (input  xpos, ypos);
  modport out (output xpos, ypos);
endinterface

// File: rtl/game_ctrl.sv
// Tom-and-Jerry game controller: round/lives/score FSM with catch detection.
// Optional round timer enabled by defining GAME_CTRL_TIMER_EN.
module game_ctrl #(
  parameter int CATCH_DIST     = 32,
  parameter int FRAMES_PER_SEC = 60,
  parameter int ROUND_SEC      = 99,
  parameter int START_LIVES    = 3,
  parameter int WIN_SCORE      = 10,
  parameter int HOLD_FRAMES    = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] reset,
  input  logic       tick,
  pos_if.in          jerrypos,
  pos_if.in          tompos,
  input  logic       cheese_got,
  output logic [2:0] state,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [6:0] round_timer,
  output logic       freeze,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    CAUGHT = 3'd2,
    OVER   = 3'd3,
    WON    = 3'd4
  } state_t;

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [1:0]    LIVES0   = 2'(START_LIVES);
  localparam logic [6:0]    ROUND0   = 7'(ROUND_SEC);
  localparam logic [7:0]    WIN      = 8'(WIN_SCORE);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_FRAMES - 1);

  state_t        st;
  logic [HW-1:0] hold_cnt;

  assign state = st;

  // Differences are taken at 13 bits so far-apart coordinates never wrap close.
  logic signed [12:0] dx, dy;
  logic        [12:0] adx, ady;
  logic               catch_hit;

  assign dx        = $signed({1'b0, tompos.xpos}) - $signed({1'b0, jerrypos.xpos});
  assign dy        = $signed({1'b0, tompos.ypos}) - $signed({1'b0, jerrypos.ypos});
  assign adx       = dx[12] ? $unsigned(-dx) : $unsigned(dx);
  assign ady       = dy[12] ? $unsigned(-dy) : $unsigned(dy);
  assign catch_hit = (adx < 13'(CATCH_DIST)) && (ady < 13'(CATCH_DIST));

  logic [7:0] score_inc;
  logic       score_can;
  assign score_inc = score + 8'd1;
  assign score_can = cheese_got && (score != 8'hff);

  logic frame_wrap;
  logic timer_expire;

`ifdef GAME_CTRL_TIMER_EN
  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  logic [FW-1:0] frame_cnt;

  assign frame_wrap   = tick && (frame_cnt == FW'(FRAMES_PER_SEC - 1));
  assign timer_expire = frame_wrap && (round_timer == 7'd1);

  // Frame counter only runs in PLAY; any other state or a restart clears it.
  always_ff @(posedge clk) begin
    if (rst || reset != 2'b00 || st != PLAY) begin
      frame_cnt <= '0;
    end else if (tick) begin
      frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
    end
  end
`else
  assign frame_wrap   = 1'b0;
  assign timer_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      score       <= 8'd0;
      lives       <= LIVES0;
      round_timer <= ROUND0;
      freeze      <= 1'b1;
      game_over   <= 1'b0;
      hold_cnt    <= '0;
    end else if (reset != 2'b00) begin
      st          <= PLAY;
      freeze      <= 1'b0;
      game_over   <= 1'b0;
      round_timer <= ROUND0;
      hold_cnt    <= '0;
      // A round restart outside an active game is a full new game.
      if (reset[1] || (st != PLAY && st != CAUGHT)) begin
        score <= 8'd0;
        lives <= LIVES0;
      end
    end else begin
      case (st)
        PLAY: begin
          if (tick && catch_hit) begin
            if (lives != 2'd0) lives <= lives - 2'd1;
            st       <= CAUGHT;
            freeze   <= 1'b1;
            hold_cnt <= '0;
          end else begin
            if (frame_wrap && round_timer != 7'd0) round_timer <= round_timer - 7'd1;
            if (score_can) score <= score_inc;
            if ((score_can && score_inc == WIN) || timer_expire) begin
              st        <= WON;
              freeze    <= 1'b1;
              game_over <= 1'b1;
            end
          end
        end
        CAUGHT: begin
          if (tick) begin
            if (hold_cnt == HOLD_END) begin
              hold_cnt <= '0;
              if (lives != 2'd0) begin
                st          <= PLAY;
                freeze      <= 1'b0;
                round_timer <= ROUND0;
              end else begin
                st        <= OVER;
                game_over <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter CATCH_DIST, 32: catch distance in pixels, per axis.
REQ-002 Parameter FRAMES_PER_SEC, 60: tick pulses per timer second.
REQ-003 Parameter ROUND_SEC, 99: round length in seconds.
REQ-004 Parameter START_LIVES, 3: Jerry lives at new game (1..3).
REQ-005 Parameter WIN_SCORE, 10: cheese count that wins the game.
REQ-006 Parameter HOLD_FRAMES, 120: ticks spent in CAUGHT before resuming.
REQ-007 clk  in  1  system clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 reset  in  2  restart code from the reset block:
- 00 none
- 01 restart round
- 10 new game
- 11 treated as 10
REQ-010 tick  in  1  one-cycle frame strobe (once per frame).
REQ-011 jerrypos  pos_if.in  -  Jerry xpos/ypos, 12 bits each, unsigned.
REQ-012 tompos  pos_if.in  -  Tom xpos/ypos, 12 bits each, unsigned.
REQ-013 cheese_got  in  1  one-cycle pulse when Jerry collects cheese.
REQ-014 state  out  3  IDLE=0, PLAY=1, CAUGHT=2, OVER=3, WON=4.
REQ-015 score  out  8  cheese collected this game.
REQ-016 lives  out  2  remaining lives.
REQ-017 round_timer  out  7  seconds left in round.
REQ-018 freeze  out  1  high = character movement blocked.
REQ-019 game_over  out  1  high in OVER or WON.

Function
REQ-020 All outputs SHALL be registered; every event SHALL be visible on outputs one clock after its sampling edge.
REQ-021 A nonzero reset code SHALL take priority over every other event in every state.
REQ-022 Code 10/11 SHALL go to PLAY with:
- score=0, lives=START_LIVES
- round_timer=ROUND_SEC, frame counter=0
REQ-023 Code 01 SHALL go to PLAY with round_timer=ROUND_SEC and frame counter=0; score and lives are kept. In IDLE, OVER or WON it SHALL behave as code 10.
REQ-024 IDLE SHALL hold, with freeze=1, until a nonzero reset code.
REQ-025 catch SHALL be true when |tx-jx|<CATCH_DIST and |ty-jy|<CATCH_DIST, using 13-bit signed differences (no wrap).
REQ-026 In PLAY, catch SHALL be evaluated only on tick. When true:
- lives decrements
- state goes to CAUGHT
- hold counter clears
REQ-027 In PLAY, cheese_got SHALL increment score on any cycle, saturating at 255.
REQ-028 If the incremented score equals WIN_SCORE, state SHALL go to WON.
REQ-029 If catch and cheese_got occur in the same cycle, catch SHALL win and score SHALL stay unchanged.
REQ-030 In PLAY, each tick SHALL advance the frame counter 0..FRAMES_PER_SEC-1. On wrap, round_timer SHALL decrement.
REQ-031 A round_timer 1->0 transition SHALL enter WON (Jerry survives) in the same cycle.
REQ-032 If catch and timer expiry fall on the same tick, catch SHALL win.
REQ-033 CAUGHT SHALL count HOLD_FRAMES ticks, then:
- lives>0: go to PLAY with round_timer=ROUND_SEC
- lives=0: go to OVER
REQ-034 In CAUGHT, cheese_got and catch SHALL be ignored.
REQ-035 OVER and WON SHALL hold until a nonzero reset code.
REQ-036 freeze SHALL be 0 only in PLAY.
REQ-037 lives SHALL never underflow below 0.

Reset
REQ-038 On rst, the block SHALL set:
- state=IDLE, score=0, lives=START_LIVES
- round_timer=ROUND_SEC, freeze=1, game_over=0
- all counters 0
REQ-039 rst SHALL override the reset code and any in-progress hold or timer count.

Configuration
REQ-040 Macro GAME_CTRL_TIMER_EN SHALL control the round timer.
- Defined: REQ-030/031 apply.
- Undefined: round_timer SHALL stay at ROUND_SEC, no timer expiry SHALL occur, and the frame counter SHALL not be built.

Verification
REQ-041 rst, then reset=10 for 1 cycle -> state=PLAY, lives=3, score=0, freeze=0 one cycle later.
REQ-042 PLAY, tom=(100,100), jerry=(131,90), tick -> CAUGHT, lives=2. With jerry=(132,90) -> stays PLAY.
REQ-043 PLAY, score=9, cheese_got pulse -> score=10, state=WON, game_over=1. Repeat with a catching tick in the same cycle -> CAUGHT, score=9.
REQ-044 lives=1, catch, then 120 ticks -> state=OVER. A further reset=01 -> PLAY, lives=3, score=0.
REQ-045 With GAME_CTRL_TIMER_EN defined: 99*60 ticks in PLAY, no catch -> round_timer=0, state=WON. Undefined: round_timer stays 99 and state stays PLAY.
REQ-046 Mid-CAUGHT (hold=50), reset=01 -> PLAY next cycle, lives unchanged, round_timer=99.
